// File: rtl/fetch_seq_pkg.sv
// fetch_seq_pkg
//   Shared definitions for the instruction-fetch sequencer:
//   - state_e   : sequencer state encoding
//   - OPC_HALT  : opcode value that stops the sequencer (used only when
//                 FETCH_HALT_EN is defined)
//   - OPC_MSB / OPC_LSB : position of the opcode field in an instruction word
package fetch_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_ISSUE = 3'd2,
    ST_GUARD = 3'd3,
    ST_EXEC  = 3'd4,
    ST_HALT  = 3'd5
  } state_e;

  localparam logic [2:0] OPC_HALT = 3'b111;
  localparam int         OPC_MSB  = 15;
  localparam int         OPC_LSB  = 13;

endpackage : fetch_seq_pkg

// File: rtl/fetch_sequencer_pc_reg.sv
// pc_reg
//   Program-counter register with asynchronous reset to RESET_PC,
//   parallel load and increment with wrap modulo 2^PC_WIDTH.
//   Load wins over increment if both are requested.
//   Written as a standalone block so branch support can reuse it later.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high; pc <= RESET_PC
//   load       in   load pc from load_data
//   load_data  in   PC_WIDTH new value
//   inc        in   pc <= pc + 1 (wraps to 0)
//   pc         out  PC_WIDTH current value
module pc_reg #(
  parameter int                   PC_WIDTH = 9,
  parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [PC_WIDTH-1:0] load_data,
  input  logic                inc,
  output logic [PC_WIDTH-1:0] pc
);

  logic [PC_WIDTH-1:0] pc_value_reg;
  logic [PC_WIDTH-1:0] pc_value_next;

  always_comb begin
    pc_value_next = pc_value_reg;
    if (load) begin
      pc_value_next = load_data;
    end else if (inc) begin
      // Natural overflow of the PC_WIDTH-bit add gives the wrap to 0.
      pc_value_next = pc_value_reg + PC_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_value_reg <= RESET_PC;
    end else begin
      pc_value_reg <= pc_value_next;
    end
  end

  assign pc = pc_value_reg;

endmodule : pc_reg

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Instruction-fetch and issue sequencer placed in front of the execute
//   controller. Reads one instruction word per loop over a req/ack
//   handshake, latches it into ir, pulses exec_start, then waits for the
//   execute controller to report completion on exec_done.
//
//   Loop: IDLE -> FETCH -> ISSUE -> GUARD -> EXEC -> (FETCH | IDLE)
//
// Build option:
//   FETCH_HALT_EN  when defined, an instruction whose opcode field equals
//                  OPC_HALT sends the sequencer to HALT instead of issuing
//                  it, and the extra output 'halted' is present.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous, active-high; back to IDLE
//   run          in   1 = fetch/execute continuously, 0 = stop after current
//   pc_load      in   load PC from pc_wdata (IDLE, or HALT with the option)
//   pc_wdata     in   PC_WIDTH new PC value
//   mem_req      out  instruction read request (state FETCH)
//   mem_addr     out  PC_WIDTH read address, equals pc
//   mem_ack      in   read data valid this cycle
//   mem_rdata    in   INSTR_WIDTH read data
//   ir           out  INSTR_WIDTH instruction register
//   exec_start   out  one-cycle start pulse to the execute controller
//   exec_done    in   execute controller is in its wait state
//   pc           out  PC_WIDTH current PC
//   instr_count  out  16-bit retired-instruction counter (wraps)
//   busy         out  1 in every state except IDLE
//   halted       out  (FETCH_HALT_EN only) 1 in HALT
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int                   PC_WIDTH    = 9,
  parameter int                   INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic                   pc_load,
  input  logic [PC_WIDTH-1:0]    pc_wdata,
  output logic                   mem_req,
  output logic [PC_WIDTH-1:0]    mem_addr,
  input  logic                   mem_ack,
  input  logic [INSTR_WIDTH-1:0] mem_rdata,
  output logic [INSTR_WIDTH-1:0] ir,
  output logic                   exec_start,
  input  logic                   exec_done,
  output logic [PC_WIDTH-1:0]    pc,
  output logic [15:0]            instr_count,
`ifdef FETCH_HALT_EN
  output logic                   halted,
`endif
  output logic                   busy
);

  state_e                 state_reg;
  state_e                 state_next;
  logic [INSTR_WIDTH-1:0] ir_reg;
  logic [15:0]            count_reg;

  logic                   pc_load_en;
  logic                   pc_inc_en;
  logic                   ir_load_en;
  logic                   count_inc_en;

  // ---------------------------------------------------------------------
  // Program counter
  // ---------------------------------------------------------------------
  pc_reg #(
    .PC_WIDTH (PC_WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (pc_load_en),
    .load_data (pc_wdata),
    .inc       (pc_inc_en),
    .pc        (pc)
  );

  // ---------------------------------------------------------------------
  // Next-state and control decode
  // ---------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    pc_load_en   = 1'b0;
    pc_inc_en    = 1'b0;
    ir_load_en   = 1'b0;
    count_inc_en = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        // A PC load in the same cycle as run keeps us in IDLE so the new
        // PC is in place before the first fetch.
        if (pc_load) begin
          pc_load_en = 1'b1;
        end else if (run) begin
          state_next = ST_FETCH;
        end
      end

      ST_FETCH: begin
        // An ack in the very first FETCH cycle is accepted, which lets a
        // zero-wait memory complete the fetch in one cycle.
        if (mem_ack) begin
          ir_load_en = 1'b1;
          pc_inc_en  = 1'b1;
`ifdef FETCH_HALT_EN
          if (mem_rdata[OPC_MSB:OPC_LSB] == OPC_HALT) begin
            state_next = ST_HALT;
          end else begin
            state_next = ST_ISSUE;
          end
`else
          state_next = ST_ISSUE;
`endif
        end
      end

      ST_ISSUE: begin
        state_next = ST_GUARD;
      end

      // The execute controller still shows its wait flag for a cycle after
      // the start pulse; ignoring exec_done here avoids retiring the
      // instruction before it has actually started.
      ST_GUARD: begin
        state_next = ST_EXEC;
      end

      ST_EXEC: begin
        if (exec_done) begin
          count_inc_en = 1'b1;
          state_next   = run ? ST_FETCH : ST_IDLE;
        end
      end

`ifdef FETCH_HALT_EN
      ST_HALT: begin
        if (pc_load) begin
          pc_load_en = 1'b1;
          state_next = ST_IDLE;
        end
      end
`endif

      // Any unused encoding (including HALT when the option is off)
      // recovers to IDLE.
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // State, instruction register and retired counter
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_reg <= '0;
    end else if (ir_load_en) begin
      ir_reg <= mem_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (count_inc_en) begin
      count_reg <= count_reg + 16'd1;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs: decoded directly from the state register
  // ---------------------------------------------------------------------
  assign mem_req     = (state_reg == ST_FETCH);
  assign exec_start  = (state_reg == ST_ISSUE);
  assign busy        = (state_reg != ST_IDLE);
  assign mem_addr    = pc;
  assign ir          = ir_reg;
  assign instr_count = count_reg;
`ifdef FETCH_HALT_EN
  assign halted      = (state_reg == ST_HALT);
`endif

endmodule : fetch_sequencer

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
//   Directed self-checking bench for fetch_sequencer. Inputs change and
//   outputs are sampled 1 time unit after each rising clock edge.
//   Define FETCH_HALT_EN to also exercise the HALT path.
module tb_fetch_sequencer;

  localparam int PW = 9;
  localparam int IW = 16;

  logic          clk;
  logic          reset;
  logic          run;
  logic          pc_load;
  logic [PW-1:0] pc_wdata;
  logic          mem_req;
  logic [PW-1:0] mem_addr;
  logic          mem_ack;
  logic [IW-1:0] mem_rdata;
  logic [IW-1:0] ir;
  logic          exec_start;
  logic          exec_done;
  logic [PW-1:0] pc;
  logic [15:0]   instr_count;
  logic          busy;
`ifdef FETCH_HALT_EN
  logic          halted;
`endif

  int checks;
  int failures;

  fetch_sequencer #(
    .PC_WIDTH    (PW),
    .INSTR_WIDTH (IW),
    .RESET_PC    ('0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .pc_load     (pc_load),
    .pc_wdata    (pc_wdata),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .ir          (ir),
    .exec_start  (exec_start),
    .exec_done   (exec_done),
    .pc          (pc),
    .instr_count (instr_count),
`ifdef FETCH_HALT_EN
    .halted      (halted),
`endif
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset held across one rising edge, released 1 unit after it.
  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    run       = 1'b0;
    pc_load   = 1'b0;
    pc_wdata  = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    exec_done = 1'b0;

    // ---------------- reset state ----------------
    tick();
    check("rst_mem_req", mem_req, 0);
    check("rst_exec_start", exec_start, 0);
    check("rst_busy", busy, 0);
    check("rst_pc", pc, 0);
    check("rst_ir", ir, 0);
    check("rst_count", instr_count, 0);

    // ---------------- zero-wait fetch of D105 ----------------
    run       = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 16'hD105;
    reset     = 1'b0;                  // cycle 0: IDLE
    tick();                            // cycle 1: FETCH
    check("zw_c1_mem_req", mem_req, 1);
    check("zw_c1_addr", mem_addr, 0);
    check("zw_c1_start", exec_start, 0);
    tick();                            // cycle 2: ISSUE
    mem_ack = 1'b0;
    check("zw_c2_start", exec_start, 1);
    check("zw_c2_mem_req", mem_req, 0);
    check("zw_ir", ir, 16'hD105);
    check("zw_pc", pc, 1);
    run = 1'b0;
    tick();                            // GUARD
    check("zw_guard_start", exec_start, 0);
    tick();                            // EXEC
    check("zw_exec_busy", busy, 1);
    exec_done = 1'b1;
    tick();                            // retire -> IDLE
    exec_done = 1'b0;
    check("zw_count", instr_count, 1);
    check("zw_idle_busy", busy, 0);

    // ---------------- 3 wait cycles before ack ----------------
    run       = 1'b1;
    mem_rdata = 16'h1234;              // present but not acked yet
    tick();                            // FETCH, wait 1
    for (int i = 0; i < 3; i++) begin
      check($sformatf("ws_req_w%0d", i), mem_req, 1);
      check($sformatf("ws_addr_w%0d", i), mem_addr, 1);
      check($sformatf("ws_ir_hold_w%0d", i), ir, 16'hD105);
      tick();
    end
    mem_ack = 1'b1;                    // 4th FETCH cycle: ack
    check("ws_req_ack", mem_req, 1);
    check("ws_addr_ack", mem_addr, 1);
    tick();                            // ISSUE
    mem_ack = 1'b0;
    run     = 1'b0;
    check("ws_ir", ir, 16'h1234);
    check("ws_pc", pc, 2);
    check("ws_start", exec_start, 1);
    tick();                            // GUARD
    tick();                            // EXEC
    exec_done = 1'b1;
    tick();                            // IDLE
    exec_done = 1'b0;
    check("ws_count", instr_count, 2);

    // ---------------- pc_load 1FF, wrap, exec_done held high ----------------
    do_reset();
    pc_load   = 1'b1;
    pc_wdata  = 9'h1FF;
    run       = 1'b1;                  // pc_load wins, stay IDLE
    tick();
    pc_load = 1'b0;
    check("ld_pc", pc, 9'h1FF);
    check("ld_busy", busy, 0);
    exec_done = 1'b1;                  // held high throughout
    mem_ack   = 1'b1;
    mem_rdata = 16'h0AAA;
    tick();                            // FETCH @1FF
    check("ld_addr1", mem_addr, 9'h1FF);
    check("ld_req1", mem_req, 1);
    tick();                            // ISSUE
    check("ld_start1", exec_start, 1);
    check("ld_pc_wrap", pc, 0);
    check("ld_ir1", ir, 16'h0AAA);
    tick();                            // GUARD: exec_done ignored
    check("ld_guard_start", exec_start, 0);
    check("ld_guard_count", instr_count, 0);
    tick();                            // EXEC, first cycle
    check("ld_exec_count", instr_count, 0);
    check("ld_exec_start", exec_start, 0);
    mem_rdata = 16'h0BBB;
    tick();                            // exit on first EXEC cycle -> FETCH @0
    check("ld_count1", instr_count, 1);
    check("ld_addr2", mem_addr, 0);
    check("ld_req2", mem_req, 1);
    tick();                            // ISSUE
    run     = 1'b0;
    mem_ack = 1'b0;
    check("ld_start2", exec_start, 1);
    check("ld_ir2", ir, 16'h0BBB);
    check("ld_pc2", pc, 1);
    tick();                            // GUARD
    tick();                            // EXEC
    tick();                            // IDLE
    exec_done = 1'b0;
    check("ld_count2", instr_count, 2);
    check("ld_final_busy", busy, 0);

    // ---------------- run dropped mid-execution ----------------
    do_reset();
    run       = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 16'h2222;
    tick();                            // FETCH
    tick();                            // ISSUE
    mem_ack = 1'b0;
    tick();                            // GUARD
    tick();                            // EXEC
    run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rd_busy_%0d", i), busy, 1);
      check($sformatf("rd_req_%0d", i), mem_req, 0);
      tick();
    end
    check("rd_count_pre", instr_count, 0);
    exec_done = 1'b1;
    tick();                            // retire -> IDLE
    exec_done = 1'b0;
    check("rd_count", instr_count, 1);
    check("rd_busy_idle", busy, 0);
    tick();
    check("rd_no_req", mem_req, 0);

    // ---------------- async reset mid-FETCH ----------------
    run = 1'b1;
    tick();                            // FETCH @1, no ack
    check("ar_req_before", mem_req, 1);
    check("ar_pc_before", pc, 1);
    #2;
    reset = 1'b1;                      // between edges
    #1;
    check("ar_req", mem_req, 0);
    check("ar_pc", pc, 0);
    check("ar_ir", ir, 0);
    check("ar_count", instr_count, 0);
    check("ar_busy", busy, 0);
    run = 1'b0;
    tick();
    reset     = 1'b0;
    mem_ack   = 1'b1;                  // stray late ack in IDLE
    mem_rdata = 16'h5A5A;
    tick();
    mem_ack = 1'b0;
    check("ar_stray_ir", ir, 0);
    check("ar_stray_pc", pc, 0);
    check("ar_stray_busy", busy, 0);

`ifdef FETCH_HALT_EN
    // ---------------- HALT opcode ----------------
    do_reset();
    run       = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 16'hE000;
    tick();                            // FETCH
    tick();                            // HALT
    mem_ack = 1'b0;
    check("ht_halted", halted, 1);
    check("ht_start", exec_start, 0);
    check("ht_busy", busy, 1);
    check("ht_ir", ir, 16'hE000);
    check("ht_pc", pc, 1);
    exec_done = 1'b1;
    tick();
    tick();
    exec_done = 1'b0;
    check("ht_still", halted, 1);
    check("ht_count", instr_count, 0);
    run      = 1'b0;
    pc_load  = 1'b1;
    pc_wdata = 9'h010;
    tick();                            // -> IDLE
    pc_load = 1'b0;
    check("ht_exit_halted", halted, 0);
    check("ht_exit_busy", busy, 0);
    check("ht_exit_pc", pc, 9'h010);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog: the directed sequence is short; a hang is a failure.
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule : tb_fetch_sequencer
